// File: rtl/ahb_master_arbiter.sv
// Shares one non-pipelined AHB-Lite master port between instruction fetch and load/store.
// Data requests win over fetch; illegal requests are answered locally without a bus transfer.
module ahb_master_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [7:0]  ROM_REGION     = 8'hA0,
  parameter logic [7:0]  RAM_REGION     = 8'hB0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic        if_err,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_write,
  input  logic [2:0]  d_fn3,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic [1:0]  htrans,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [3:0]  hprot,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  localparam logic [7:0] TIMEOUT_LIM = TIMEOUT_CYCLES[7:0];

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        gnt_d_reg, gnt_d_next;
  logic [31:0] lat_addr_reg, lat_addr_next;
  logic        lat_write_reg, lat_write_next;
  logic [2:0]  lat_fn3_reg, lat_fn3_next;
  logic [31:0] lat_wdata_reg, lat_wdata_next;

  logic [1:0]  htrans_reg, htrans_next;
  logic [31:0] haddr_reg, haddr_next;
  logic        hwrite_reg, hwrite_next;
  logic [2:0]  hsize_reg, hsize_next;
  logic [3:0]  hprot_reg, hprot_next;
  logic [31:0] hwdata_reg, hwdata_next;
  logic        if_done_reg, if_done_next;
  logic        if_err_reg, if_err_next;
  logic [31:0] if_rdata_reg, if_rdata_next;
  logic        d_done_reg, d_done_next;
  logic        d_err_reg, d_err_next;
  logic [31:0] d_rdata_reg, d_rdata_next;

  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        d_fn3_ok, d_align_ok, d_illegal, if_illegal;
  logic [31:0] lane, load_ext, store_data;
  logic [2:0]  d_hsize;

  always_comb begin
    d_fn3_ok = (d_fn3 == 3'b000) || (d_fn3 == 3'b001) || (d_fn3 == 3'b010) ||
               (d_fn3 == 3'b100) || (d_fn3 == 3'b101);
    case (d_fn3[1:0])
      2'b01:   d_align_ok = (d_addr[0] == 1'b0);
      2'b10:   d_align_ok = (d_addr[1:0] == 2'b00);
      default: d_align_ok = 1'b1;
    endcase
    d_illegal  = (d_addr[31:24] != RAM_REGION) || !d_fn3_ok || !d_align_ok;
    if_illegal = (if_addr[31:24] != ROM_REGION) || (if_addr[1:0] != 2'b00);
    case (d_fn3[1:0])
      2'b00:   d_hsize = 3'b000;
      2'b01:   d_hsize = 3'b001;
      default: d_hsize = 3'b010;
    endcase
  end

  // Load lane is picked by the latched byte offset, then sign/zero extended by funct3.
  always_comb begin
    lane = hrdata >> {lat_addr_reg[1:0], 3'b000};
    case (lat_fn3_reg)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'd0, lane[7:0]};
      3'b101:  load_ext = {16'd0, lane[15:0]};
      default: load_ext = hrdata;
    endcase
    case (lat_fn3_reg[1:0])
      2'b00:   store_data = {4{lat_wdata_reg[7:0]}};
      2'b01:   store_data = {2{lat_wdata_reg[15:0]}};
      default: store_data = lat_wdata_reg;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    gnt_d_next     = gnt_d_reg;
    lat_addr_next  = lat_addr_reg;
    lat_write_next = lat_write_reg;
    lat_fn3_next   = lat_fn3_reg;
    lat_wdata_next = lat_wdata_reg;
    htrans_next    = 2'b00;
    haddr_next     = haddr_reg;
    hwrite_next    = hwrite_reg;
    hsize_next     = hsize_reg;
    hprot_next     = hprot_reg;
    hwdata_next    = hwdata_reg;
    resp_valid     = 1'b0;
    resp_err       = 1'b0;
    resp_rdata     = 32'd0;

    case (state_reg)
      IDLE: begin
        cnt_next = 8'd0;
        if (d_req || if_req) begin
          gnt_d_next     = d_req;
          lat_addr_next  = d_req ? d_addr : if_addr;
          lat_write_next = d_req & d_write;
          lat_fn3_next   = d_req ? d_fn3 : 3'b010;
          lat_wdata_next = d_wdata;
          if (d_req ? d_illegal : if_illegal) begin
            state_next = RESP;
            resp_valid = 1'b1;
            resp_err   = 1'b1;
          end else begin
            state_next  = ADDR;
            htrans_next = 2'b10;
            haddr_next  = d_req ? d_addr : if_addr;
            hwrite_next = d_req & d_write;
            hsize_next  = d_req ? d_hsize : 3'b010;
            hprot_next  = d_req ? 4'b0001 : 4'b0000;
          end
        end
      end
      ADDR, DATA: begin
        if (hready) begin
          if (state_reg == ADDR) begin
            state_next  = DATA;
            hwdata_next = lat_write_reg ? store_data : 32'd0;
          end else begin
            state_next = RESP;
            resp_valid = 1'b1;
            resp_err   = hresp;
            if (!hresp && !lat_write_reg)
              resp_rdata = gnt_d_reg ? load_ext : hrdata;
          end
        end else begin
          cnt_next = cnt_reg + 8'd1;
          if (cnt_next == TIMEOUT_LIM) begin
            state_next = RESP;
            resp_valid = 1'b1;
            resp_err   = 1'b1;
          end else if (state_reg == ADDR) begin
            htrans_next = 2'b10;
          end
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if_done_next  = resp_valid & ~gnt_d_next;
    if_err_next   = resp_valid & ~gnt_d_next & resp_err;
    d_done_next   = resp_valid & gnt_d_next;
    d_err_next    = resp_valid & gnt_d_next & resp_err;
    if_rdata_next = (resp_valid && !gnt_d_next) ? resp_rdata : if_rdata_reg;
    d_rdata_next  = (resp_valid && gnt_d_next) ? resp_rdata : d_rdata_reg;
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_reg     <= IDLE;
      cnt_reg       <= 8'd0;
      gnt_d_reg     <= 1'b0;
      lat_addr_reg  <= 32'd0;
      lat_write_reg <= 1'b0;
      lat_fn3_reg   <= 3'b010;
      lat_wdata_reg <= 32'd0;
      htrans_reg    <= 2'b00;
      haddr_reg     <= 32'd0;
      hwrite_reg    <= 1'b0;
      hsize_reg     <= 3'b010;
      hprot_reg     <= 4'b0000;
      hwdata_reg    <= 32'd0;
      if_done_reg   <= 1'b0;
      if_err_reg    <= 1'b0;
      if_rdata_reg  <= 32'd0;
      d_done_reg    <= 1'b0;
      d_err_reg     <= 1'b0;
      d_rdata_reg   <= 32'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      gnt_d_reg     <= gnt_d_next;
      lat_addr_reg  <= lat_addr_next;
      lat_write_reg <= lat_write_next;
      lat_fn3_reg   <= lat_fn3_next;
      lat_wdata_reg <= lat_wdata_next;
      htrans_reg    <= htrans_next;
      haddr_reg     <= haddr_next;
      hwrite_reg    <= hwrite_next;
      hsize_reg     <= hsize_next;
      hprot_reg     <= hprot_next;
      hwdata_reg    <= hwdata_next;
      if_done_reg   <= if_done_next;
      if_err_reg    <= if_err_next;
      if_rdata_reg  <= if_rdata_next;
      d_done_reg    <= d_done_next;
      d_err_reg     <= d_err_next;
      d_rdata_reg   <= d_rdata_next;
    end
  end

  assign htrans   = htrans_reg;
  assign haddr    = haddr_reg;
  assign hwrite   = hwrite_reg;
  assign hsize    = hsize_reg;
  assign hprot    = hprot_reg;
  assign hwdata   = hwdata_reg;
  assign if_done  = if_done_reg;
  assign if_err   = if_err_reg;
  assign if_rdata = if_rdata_reg;
  assign d_done   = d_done_reg;
  assign d_err    = d_err_reg;
  assign d_rdata  = d_rdata_reg;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: fetch, loads, stores, arbitration, errors, timeout, reset.
module tb_ahb_master_arbiter;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done, if_err;
  logic [31:0] if_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_write;
  logic [2:0]  d_fn3;
  logic [31:0] d_wdata;
  logic        d_done, d_err;
  logic [31:0] d_rdata;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready, hresp;

  int checks = 0;
  int errors = 0;

  ahb_master_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_err(if_err), .if_rdata(if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_write(d_write), .d_fn3(d_fn3), .d_wdata(d_wdata),
    .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hprot(hprot),
    .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  // Zero-wait data transfer: issue in IDLE, check ADDR, DATA and the done cycle, then release.
  task automatic data_xfer(input string tag, input logic wr, input logic [2:0] fn3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rd, input logic [2:0] exp_size,
                           input logic [31:0] exp_hwdata, input logic [31:0] exp_rdata);
    d_req = 1'b1; d_write = wr; d_fn3 = fn3; d_addr = addr; d_wdata = wdata; hrdata = rd;
    tick();
    check({tag, "_htrans"}, {30'd0, htrans}, 32'h2);
    check({tag, "_hsize"},  {29'd0, hsize}, {29'd0, exp_size});
    check({tag, "_hwrite"}, {31'd0, hwrite}, {31'd0, wr});
    check({tag, "_haddr"},  haddr, addr);
    tick();
    check({tag, "_data_tr"}, {30'd0, htrans}, 32'h0);
    if (wr) check({tag, "_hwdata"}, hwdata, exp_hwdata);
    tick();
    check({tag, "_done"},  {31'd0, d_done}, 32'h1);
    check({tag, "_err"},   {31'd0, d_err}, 32'h0);
    check({tag, "_rdata"}, d_rdata, exp_rdata);
    d_req = 1'b0;
    tick();
    check({tag, "_idle"}, {31'd0, d_done}, 32'h0);
  endtask

  initial begin
    hresetn = 1'b0; if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_addr = 32'd0;
    d_write = 1'b0; d_fn3 = 3'b010; d_wdata = 32'd0; hrdata = 32'd0; hready = 1'b1; hresp = 1'b0;
    tick(); tick();
    check("rst_htrans", {30'd0, htrans}, 32'h0);
    check("rst_hsize",  {29'd0, hsize}, 32'h2);
    check("rst_hprot",  {28'd0, hprot}, 32'h0);
    check("rst_haddr",  haddr, 32'h0);
    check("rst_done",   {30'd0, if_done, d_done}, 32'h0);
    hresetn = 1'b1;
    tick();

    // Fetch, zero wait states
    if_req = 1'b1; if_addr = 32'hA000_0010; hrdata = 32'h0051_3023;
    tick();
    check("f_htrans", {30'd0, htrans}, 32'h2);
    check("f_hsize",  {29'd0, hsize}, 32'h2);
    check("f_hprot",  {28'd0, hprot}, 32'h0);
    check("f_haddr",  haddr, 32'hA000_0010);
    tick();
    check("f_dphase", {30'd0, htrans}, 32'h0);
    check("f_nodone", {31'd0, if_done}, 32'h0);
    tick();
    check("f_done",  {31'd0, if_done}, 32'h1);
    check("f_err",   {31'd0, if_err}, 32'h0);
    check("f_rdata", if_rdata, 32'h0051_3023);
    if_req = 1'b0;
    tick();
    check("f_idle", {31'd0, if_done}, 32'h0);

    data_xfer("lb",  1'b0, 3'b000, 32'hB000_0003, 32'h0, 32'h80FF_FFFF, 3'b000, 32'h0, 32'hFFFF_FF80);
    data_xfer("lbu", 1'b0, 3'b100, 32'hB000_0003, 32'h0, 32'h80FF_FFFF, 3'b000, 32'h0, 32'h0000_0080);
    data_xfer("lh",  1'b0, 3'b001, 32'hB000_0002, 32'h0, 32'h8001_7FFF, 3'b001, 32'h0, 32'hFFFF_8001);
    data_xfer("sh",  1'b1, 3'b001, 32'hB000_0002, 32'h1234_ABCD, 32'h0, 3'b001, 32'hABCD_ABCD, 32'h0);
    data_xfer("sb",  1'b1, 3'b000, 32'hB000_0001, 32'h0000_005A, 32'h0, 3'b000, 32'h5A5A_5A5A, 32'h0);

    // Simultaneous requests: data first, fetch afterwards
    if_req = 1'b1; if_addr = 32'hA000_0020;
    d_req = 1'b1; d_write = 1'b0; d_fn3 = 3'b010; d_addr = 32'hB000_0004; hrdata = 32'hCAFE_F00D;
    tick();
    check("arb_hprot1", {28'd0, hprot}, 32'h1);
    check("arb_haddr1", haddr, 32'hB000_0004);
    tick(); tick();
    check("arb_ddone",  {30'd0, if_done, d_done}, 32'h1);
    check("arb_drdata", d_rdata, 32'hCAFE_F00D);
    d_req = 1'b0; hrdata = 32'h0000_0013;
    tick();
    check("arb_gap", {30'd0, htrans}, 32'h0);
    tick();
    check("arb_htrans2", {30'd0, htrans}, 32'h2);
    check("arb_hprot2",  {28'd0, hprot}, 32'h0);
    check("arb_haddr2",  haddr, 32'hA000_0020);
    tick(); tick();
    check("arb_fdone", {30'd0, if_done, d_done}, 32'h2);
    check("arb_frdata", if_rdata, 32'h0000_0013);
    if_req = 1'b0;
    tick();
    check("arb_quiet", {30'd0, if_done, d_done}, 32'h0);

    // Two-cycle AHB error response on a load
    d_req = 1'b1; d_fn3 = 3'b010; d_addr = 32'hB000_0008;
    tick(); tick();
    hready = 1'b0; hresp = 1'b1;
    tick();
    check("herr_wait", {31'd0, d_done}, 32'h0);
    hready = 1'b1;
    tick();
    check("herr_done", {31'd0, d_done}, 32'h1);
    check("herr_err",  {31'd0, d_err}, 32'h1);
    d_req = 1'b0; hresp = 1'b0;
    tick();

    // Misaligned word load: rejected locally
    d_req = 1'b1; d_fn3 = 3'b010; d_addr = 32'hB000_0002;
    tick();
    check("mis_htrans", {30'd0, htrans}, 32'h0);
    check("mis_done",   {31'd0, d_done}, 32'h1);
    check("mis_err",    {31'd0, d_err}, 32'h1);
    d_req = 1'b0;
    tick();
    check("mis_htrans2", {30'd0, htrans}, 32'h0);

    // Fetch outside ROM and data with bad funct3: rejected locally
    if_req = 1'b1; if_addr = 32'hC000_0000;
    tick();
    check("bad_fetch", {30'd0, if_done, if_err}, 32'h3);
    check("bad_f_htr", {30'd0, htrans}, 32'h0);
    if_req = 1'b0;
    tick();
    d_req = 1'b1; d_fn3 = 3'b011; d_addr = 32'hB000_0000;
    tick();
    check("bad_fn3", {30'd0, d_done, d_err}, 32'h3);
    d_req = 1'b0;
    tick();

    // Timeout: hready held low, abort after 4 wait cycles
    hready = 1'b0;
    d_req = 1'b1; d_fn3 = 3'b010; d_addr = 32'hB000_000C;
    tick(); tick(); tick(); tick();
    check("to_wait", {30'd0, htrans}, 32'h2);
    check("to_nodone", {31'd0, d_done}, 32'h0);
    tick();
    check("to_done",   {30'd0, d_done, d_err}, 32'h3);
    check("to_htrans", {30'd0, htrans}, 32'h0);
    check("to_rdata",  d_rdata, 32'h0);
    d_req = 1'b0; hready = 1'b1;
    tick();

    // Reset asserted during a data phase
    d_req = 1'b1; d_fn3 = 3'b010; d_addr = 32'hB000_0010;
    tick(); tick();
    hready = 1'b0; hresetn = 1'b0;
    tick();
    check("rmid_htrans", {30'd0, htrans}, 32'h0);
    check("rmid_done",   {31'd0, d_done}, 32'h0);
    check("rmid_hsize",  {29'd0, hsize}, 32'h2);
    d_req = 1'b0; hready = 1'b1; hresetn = 1'b1;
    tick();
    check("rmid_after", {30'd0, if_done, d_done}, 32'h0);
    tick();
    check("rmid_idle", {30'd0, htrans}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
